// File: rtl/spi_px_master_pkg.sv
// Shared types, defaults and helpers for the gray/Sobel pixel SPI link.
// Both the initiator and the slave side import this package.
package spi_px_master_pkg;

    localparam int MAX_PIXEL_BITS     = 24;
    localparam int SPI_MASTER_CLK_DIV = 4;
    localparam int SPI_MASTER_CS_GAP  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_master_state_t;

    // Low byte travels first; the mapping is its own inverse.
    function automatic logic [23:0] swap_bytes24(input logic [23:0] word);
        return {word[7:0], word[15:8], word[23:16]};
    endfunction

endpackage

// File: rtl/spi_px_master_sck_gen.sv
// Half-period timer: phase_end pulses on the last cycle of every CLK_DIV-cycle
// SCK phase while enabled; the count restarts on every phase boundary.
module spi_px_master_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic clr,
    output logic phase_end
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign phase_end = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!nreset || clr || !en || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_px_master.sv
// SPI mode-0 initiator: sends one byte-swapped gray pixel per chip-select frame
// and returns the Sobel word clocked back from the slave as a one-cycle strobe.
module spi_px_master
    import spi_px_master_pkg::*;
#(
    parameter int WORD_SIZE = MAX_PIXEL_BITS,
    parameter int CLK_DIV   = SPI_MASTER_CLK_DIV,
    parameter int CS_GAP    = SPI_MASTER_CS_GAP
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic [WORD_SIZE-1:0] px_i,
    input  logic                 px_valid_i,
    output logic                 px_ready_o,
    output logic [WORD_SIZE-1:0] result_o,
    output logic                 result_valid_o,
    output logic                 busy_o,
    output logic                 spi_sck_o,
    output logic                 spi_sdo_o,
    input  logic                 spi_sdi_i,
    output logic                 spi_cs_o
);

    localparam int BIT_W    = $clog2(WORD_SIZE);
    // Last SCK fall to CS rise: flushes the final MISO bit through the
    // synchroniser and leaves the slave a full half-period of CS hold.
    localparam int HOLD_LEN = 2 * CLK_DIV + 1;
    localparam int WAIT_MAX = (HOLD_LEN > CS_GAP) ? HOLD_LEN : CS_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX);

    function automatic logic [WORD_SIZE-1:0] swap_bytes(input logic [WORD_SIZE-1:0] word);
        logic [WORD_SIZE-1:0] res;
        res = '0;
        for (int b = 0; b < WORD_SIZE / 8; b++) begin
            res[8*b +: 8] = word[WORD_SIZE-8-8*b +: 8];
        end
        return res;
    endfunction

    spi_master_state_t     state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WORD_SIZE-1:0]  tx_sr;
    logic [WORD_SIZE-1:0]  rx_sr;
    logic [WORD_SIZE-1:0]  px_swapped;
    logic                  sdi_meta;
    logic                  sdi_sync;
    logic                  accept;
    logic                  sck_en;
    logic                  phase_end;

    assign px_swapped = swap_bytes(px_i);
    assign accept     = (state == ST_IDLE) && px_valid_i && px_ready_o;
    assign sck_en     = (state == ST_SETUP) || (state == ST_HIGH) || (state == ST_LOW);

    spi_px_master_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk      (clk_i),
        .nreset   (nreset_i),
        .en       (sck_en),
        .clr      (accept),
        .phase_end(phase_end)
    );

    // MISO is asynchronous to clk_i.
    always_ff @(posedge clk_i) begin
        sdi_meta <= spi_sdi_i;
        sdi_sync <= sdi_meta;
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state          <= ST_IDLE;
            spi_cs_o       <= 1'b1;
            spi_sck_o      <= 1'b0;
            spi_sdo_o      <= 1'b0;
            px_ready_o     <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
        end else begin
            result_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    px_ready_o <= 1'b1;
                    if (accept) begin
                        tx_sr      <= px_swapped;
                        spi_sdo_o  <= px_swapped[WORD_SIZE-1];
                        bit_cnt    <= '0;
                        spi_cs_o   <= 1'b0;
                        px_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        spi_sck_o <= 1'b1;
                        state     <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        spi_sck_o <= 1'b0;
                        rx_sr     <= {rx_sr[WORD_SIZE-2:0], sdi_sync};
                        if (bit_cnt == BIT_W'(WORD_SIZE - 1)) begin
                            wait_cnt <= '0;
                            state    <= ST_HOLD;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            tx_sr     <= {tx_sr[WORD_SIZE-2:0], 1'b0};
                            spi_sdo_o <= tx_sr[WORD_SIZE-2];
                            state     <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        spi_sck_o <= 1'b1;
                        state     <= ST_HIGH;
                    end
                end
                ST_HOLD: begin
                    if (wait_cnt == WAIT_W'(HOLD_LEN - 1)) begin
                        spi_cs_o       <= 1'b1;
                        spi_sdo_o      <= 1'b0;
                        result_o       <= swap_bytes(rx_sr);
                        result_valid_o <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= ST_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (wait_cnt == WAIT_W'(CS_GAP - 1)) begin
                        busy_o     <= 1'b0;
                        px_ready_o <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
